// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains four input FIFOs round-robin and routes each popped
// word to one of four destination FIFOs chosen by the word's top two bits.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | all input FIFOs empty; no pops issued
// ACTIVE | popping one word per cycle from the next non-empty lane
// STALL  | a destination is almost full; pops held, in-flight words drain
//
// Any almost-full flag blocks every pop, whatever the destination. Up to two
// words can already be in flight when a flag rises, and those are always
// pushed, so destination thresholds must leave room for two words.
module fifo_rr_arbiter #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            fifo_empty,
  input  logic [4*DATA_W-1:0]   fifo_data,
  output logic [3:0]            fifo_rd_enb,
  input  logic [3:0]            out_alm_full,
  output logic [3:0]            out_wr_enb,
  output logic [DATA_W-1:0]     out_data,
  output logic                  idle,
  input  logic [1:0]            cnt_sel,
  output logic [CNT_W-1:0]      cnt_value
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        ptr_q, ptr_d;
  logic              grant;
  logic [1:0]        gnt_lane;
  logic [1:0]        cand;

  logic              s1_vld_q;
  logic [1:0]        s1_lane_q;
  logic [DATA_W-1:0] s1_word;
  logic [1:0]        s1_dest;

  logic [3:0]        out_wr_enb_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  cnt_q [4];

  logic any_ready;
  logic stall;

  assign any_ready = ~(&fifo_empty);
  assign stall     = |out_alm_full;

  // Next-state decode for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_ready) begin
          state_d = stall ? ST_STALL : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (stall) begin
          state_d = ST_STALL;
        end else if (!any_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (!stall) begin
          state_d = any_ready ? ST_ACTIVE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-robin search from the pointer; grant is issued in the same cycle
  // the FSM is (or is becoming) ACTIVE so a fresh lane costs no extra cycle.
  always_comb begin
    grant    = 1'b0;
    gnt_lane = ptr_q;
    cand     = ptr_q;
    if (state_d == ST_ACTIVE && !stall) begin
      for (int k = 0; k < 4; k++) begin
        cand = ptr_q + 2'(k);
        if (!grant && !fifo_empty[cand]) begin
          grant    = 1'b1;
          gnt_lane = cand;
        end
      end
    end
    ptr_d = grant ? (gnt_lane + 2'd1) : ptr_q;
  end

  assign fifo_rd_enb = grant ? (4'b0001 << gnt_lane) : 4'b0000;

  // Pick the popped lane's read data, valid the cycle after the pop.
  always_comb begin
    s1_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (s1_lane_q == 2'(k)) begin
        s1_word = fifo_data[DATA_W*k +: DATA_W];
      end
    end
    s1_dest = s1_word[DATA_W-1 -: 2];
  end

  // FSM state and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Two-stage pop-to-push pipeline; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_lane_q    <= 2'd0;
      out_wr_enb_q <= 4'b0000;
      out_data_q   <= '0;
    end else begin
      s1_vld_q  <= grant;
      s1_lane_q <= gnt_lane;
      if (s1_vld_q) begin
        out_data_q   <= s1_word;
        out_wr_enb_q <= 4'b0001 << s1_dest;
      end else begin
        out_wr_enb_q <= 4'b0000;
      end
    end
  end

  // Per-destination forwarded-word counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 4; j++) begin
        cnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (out_wr_enb_q[j]) begin
          cnt_q[j] <= cnt_q[j] + CNT_W'(1);
        end
      end
    end
  end

  assign out_wr_enb = out_wr_enb_q;
  assign out_data   = out_data_q;
  assign idle       = (state_q == ST_IDLE) && !s1_vld_q && !(|out_wr_enb_q);
  assign cnt_value  = cnt_q[cnt_sel];

endmodule
